// File: rtl/fetch_ctrl_if.sv
// Decode/hazard inputs and fetch-control outputs between the ID stage and fetch_ctrl.
interface fetch_ctrl_if;
   logic       br_op_id;
   logic       cbz_id;
   logic       uncond_id;
   logic       brtaken_id;
   logic [4:0] br_reg_id;
   logic       ex_wr_en;
   logic       ex_mem_read;
   logic [4:0] ex_rd;
   logic       mem_wr_en;
   logic [4:0] mem_rd;
   logic       pc_we;
   logic       ifid_we;
   logic       ifid_flush;
   logic [1:0] forward_br;

   modport master (
      output br_op_id, cbz_id, uncond_id, brtaken_id, br_reg_id,
      output ex_wr_en, ex_mem_read, ex_rd, mem_wr_en, mem_rd,
      input  pc_we, ifid_we, ifid_flush, forward_br
   );

   modport slave (
      input  br_op_id, cbz_id, uncond_id, brtaken_id, br_reg_id,
      input  ex_wr_en, ex_mem_read, ex_rd, mem_wr_en, mem_rd,
      output pc_we, ifid_we, ifid_flush, forward_br
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch control: load-use stall, branch redirect flush, BR/CBZ operand forwarding; outputs are combinational.
// Stalls by dropping pc_we/ifid_we for one cycle; FETCH_CTRL_STATS_EN adds saturating stall/redirect counters.
module fetch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   fetch_ctrl_if.slave fc
`ifdef FETCH_CTRL_STATS_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] redir_cnt
`endif
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_LDSTALL = 2'd1;
   localparam logic [1:0] ST_REDIR   = 2'd2;

   logic [1:0] state_q, state_d;
   logic       reg_use, ex_match, mem_match, load_use, redirect_req;
   logic       pc_we, ifid_we, ifid_flush;
   logic [1:0] forward_br;

   always_comb begin
      reg_use      = (fc.br_op_id | fc.cbz_id) & (fc.br_reg_id != 5'd31);
      ex_match     = fc.ex_wr_en & (fc.ex_rd == fc.br_reg_id);
      mem_match    = fc.mem_wr_en & (fc.mem_rd == fc.br_reg_id);
      load_use     = (state_q == ST_RUN) & reg_use & ex_match & fc.ex_mem_read;
      redirect_req = fc.uncond_id | fc.br_op_id | fc.brtaken_id;

      if (reg_use && ex_match && !fc.ex_mem_read) begin
         forward_br = 2'b10;
      end else if (reg_use && mem_match) begin
         forward_br = 2'b01;
      end else begin
         forward_br = 2'b00;
      end

      state_d    = ST_RUN;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      case (state_q)
         ST_RUN: begin
            // Hazard takes precedence; any branch is re-evaluated in LDSTALL.
            if (load_use) begin
               pc_we   = 1'b0;
               ifid_we = 1'b0;
               state_d = ST_LDSTALL;
            end else if (redirect_req) begin
               ifid_flush = 1'b1;
               state_d    = ST_REDIR;
            end
         end
         ST_LDSTALL: begin
            if (redirect_req) begin
               ifid_flush = 1'b1;
               state_d    = ST_REDIR;
            end
         end
         // Second wrong-path fetch arrives late from synchronous imem; squash it too.
         ST_REDIR: ifid_flush = 1'b1;
         default:  state_d    = ST_RUN;
      endcase

      if (!rst_n) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b1;
         forward_br = 2'b00;
         state_d    = ST_RUN;
      end
   end

   assign fc.pc_we      = pc_we;
   assign fc.ifid_we    = ifid_we;
   assign fc.ifid_flush = ifid_flush;
   assign fc.forward_br = forward_br;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef FETCH_CTRL_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if ((state_d == ST_LDSTALL) && (state_q != ST_LDSTALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_d == ST_REDIR) && (state_q != ST_REDIR) && (redir_cnt_q != 32'hFFFF_FFFF)) begin
         redir_cnt_d = redir_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
         redir_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expectations queued at drive time, popped when outputs are sampled.
module tb_fetch_ctrl;

   typedef struct packed {
      logic       br;
      logic       cbz;
      logic       unc;
      logic       tk;
      logic [4:0] rg;
      logic       exw;
      logic       exm;
      logic [4:0] exrd;
      logic       mw;
      logic [4:0] mrd;
   } in_t;

   typedef struct packed {
      logic [4:0] val;
      logic [4:0] care;
   } exp_t;

   localparam logic [4:0] ALL    = 5'b11111;
   localparam logic [4:0] NO_IFW = 5'b10111;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   exp_stall;
   int   exp_redir;
   exp_t exp_q[$];

   fetch_ctrl_if fc ();

`ifdef FETCH_CTRL_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] redir_cnt;
   fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .fc(fc), .stall_cnt(stall_cnt), .redir_cnt(redir_cnt));
`else
   fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .fc(fc));
`endif

   always #5 clk = ~clk;

   function automatic in_t mk(input logic br, input logic cbz, input logic unc, input logic tk,
                              input logic [4:0] rg, input logic exw, input logic exm,
                              input logic [4:0] exrd, input logic mw, input logic [4:0] mrd);
      in_t v;
      v = '{br, cbz, unc, tk, rg, exw, exm, exrd, mw, mrd};
      return v;
   endfunction

   function automatic logic [4:0] outs();
      return {fc.pc_we, fc.ifid_we, fc.ifid_flush, fc.forward_br};
   endfunction

   task automatic drive(input in_t v);
      fc.br_op_id    = v.br;
      fc.cbz_id      = v.cbz;
      fc.uncond_id   = v.unc;
      fc.brtaken_id  = v.tk;
      fc.br_reg_id   = v.rg;
      fc.ex_wr_en    = v.exw;
      fc.ex_mem_read = v.exm;
      fc.ex_rd       = v.exrd;
      fc.mem_wr_en   = v.mw;
      fc.mem_rd      = v.mrd;
   endtask

   task automatic push_exp(input logic [4:0] val, input logic [4:0] care);
      exp_t e;
      e.val  = val;
      e.care = care;
      exp_q.push_back(e);
   endtask

   task automatic check_counters(input string name);
`ifdef FETCH_CTRL_STATS_EN
      total++;
      if (stall_cnt !== 32'(exp_stall)) begin
         bad++;
         $display("FAIL %s stall_cnt got=%0d want=%0d", name, stall_cnt, exp_stall);
      end
      total++;
      if (redir_cnt !== 32'(exp_redir)) begin
         bad++;
         $display("FAIL %s redir_cnt got=%0d want=%0d", name, redir_cnt, exp_redir);
      end
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      drive(mk(1, 0, 0, 0, 5'd5, 1, 0, 5'd5, 1, 5'd5));
      repeat (3) @(posedge clk);
      push_exp(5'b00100, ALL);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ((outs() & e.care) !== (e.val & e.care)) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=%b", outs(), e.val);
      end
      exp_stall = 0;
      exp_redir = 0;
      check_counters("reset");
      drive(mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
      rst_n = 1'b1;
   endtask

   task automatic test_plain_fetch();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
         push_exp(5'b11000, ALL);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL plain_fetch cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
   endtask

   task automatic test_load_use_taken();
      in_t        v[4];
      logic [4:0] w[4];
      exp_t       e;
      v[0] = mk(0, 1, 0, 1, 5'd3, 1, 1, 5'd3, 0, 5'd0);  w[0] = 5'b00000;
      v[1] = mk(0, 1, 0, 1, 5'd3, 0, 0, 5'd0, 1, 5'd3);  w[1] = 5'b11101;
      v[2] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[2] = 5'b11100;
      v[3] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[3] = 5'b11000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], ALL);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL load_use_taken cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
      exp_stall++;
      exp_redir++;
      check_counters("load_use_taken");
   endtask

   task automatic test_load_use_not_taken();
      in_t        v[3];
      logic [4:0] w[3];
      exp_t       e;
      v[0] = mk(0, 1, 0, 0, 5'd4, 1, 1, 5'd4, 0, 5'd0);  w[0] = 5'b00000;
      v[1] = mk(0, 1, 0, 0, 5'd4, 0, 0, 5'd0, 1, 5'd4);  w[1] = 5'b11001;
      v[2] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[2] = 5'b11000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], ALL);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL load_use_not_taken cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
      exp_stall++;
      check_counters("load_use_not_taken");
   endtask

   task automatic test_ex_forward();
      in_t        v[3];
      logic [4:0] w[3];
      logic [4:0] c[3];
      exp_t       e;
      v[0] = mk(1, 0, 0, 0, 5'd5, 1, 0, 5'd5, 0, 5'd0);  w[0] = 5'b10110;  c[0] = NO_IFW;
      v[1] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[1] = 5'b11100;  c[1] = ALL;
      v[2] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[2] = 5'b11000;  c[2] = ALL;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], c[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL ex_forward cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
      exp_redir++;
      check_counters("ex_forward");
   endtask

   task automatic test_forward_priority();
      in_t        v[6];
      logic [4:0] w[6];
      exp_t       e;
      v[0] = mk(0, 1, 0, 0, 5'd7, 1, 0, 5'd7, 1, 5'd7);    w[0] = 5'b11010;
      v[1] = mk(0, 1, 0, 0, 5'd7, 0, 0, 5'd7, 1, 5'd7);    w[1] = 5'b11001;
      v[2] = mk(0, 1, 0, 0, 5'd7, 1, 0, 5'd8, 1, 5'd7);    w[2] = 5'b11001;
      v[3] = mk(0, 1, 0, 0, 5'd7, 0, 0, 5'd7, 0, 5'd7);    w[3] = 5'b11000;
      v[4] = mk(0, 0, 0, 0, 5'd7, 1, 0, 5'd7, 1, 5'd7);    w[4] = 5'b11000;
      v[5] = mk(0, 1, 0, 0, 5'd31, 1, 0, 5'd31, 1, 5'd31); w[5] = 5'b11000;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], ALL);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL forward_priority vec%0d got=%b want=%b", i, outs(), e.val);
         end
      end
   endtask

   task automatic test_xzr();
      in_t        v[3];
      logic [4:0] w[3];
      logic [4:0] c[3];
      exp_t       e;
      v[0] = mk(1, 0, 0, 0, 5'd31, 1, 1, 5'd31, 0, 5'd0);  w[0] = 5'b10100;  c[0] = NO_IFW;
      v[1] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);    w[1] = 5'b11100;  c[1] = ALL;
      v[2] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);    w[2] = 5'b11000;  c[2] = ALL;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], c[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL xzr cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
      exp_redir++;
      check_counters("xzr");
   endtask

   task automatic test_redir_ignores_decode();
      in_t        v[3];
      logic [4:0] w[3];
      logic [4:0] c[3];
      exp_t       e;
      v[0] = mk(0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[0] = 5'b10100;  c[0] = NO_IFW;
      v[1] = mk(0, 1, 1, 1, 5'd2, 1, 1, 5'd2, 0, 5'd0);  w[1] = 5'b11100;  c[1] = ALL;
      v[2] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0);  w[2] = 5'b11000;  c[2] = ALL;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         drive(v[i]);
         push_exp(w[i], c[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL redir_ignore cyc%0d got=%b want=%b", i, outs(), e.val);
         end
      end
      exp_redir++;
      check_counters("redir_ignore");
   endtask

   task automatic test_reset_mid_flight();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            drive(mk(0, 1, 0, 0, 5'd3, 1, 1, 5'd3, 0, 5'd0));
            push_exp(5'b00000, ALL);
         end else begin
            drive(mk(0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
            push_exp(5'b10100, NO_IFW);
         end
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL reset_mid_enter k%0d got=%b want=%b", k, outs(), e.val);
         end
         @(posedge clk); #1;
         drive(mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
         rst_n = 1'b0;
         push_exp(5'b00100, ALL);
         #1;
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL reset_mid_assert k%0d got=%b want=%b", k, outs(), e.val);
         end
         exp_stall = 0;
         exp_redir = 0;
         check_counters("reset_mid");
         @(negedge clk);
         rst_n = 1'b1;
         @(posedge clk); #1;
         push_exp(5'b11000, ALL);
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if ((outs() & e.care) !== (e.val & e.care)) begin
            bad++;
            $display("FAIL reset_mid_release k%0d got=%b want=%b", k, outs(), e.val);
         end
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst_n     = 1'b0;
      total     = 0;
      bad       = 0;
      exp_stall = 0;
      exp_redir = 0;
      test_reset();
      test_plain_fetch();
      test_load_use_taken();
      test_load_use_not_taken();
      test_ex_forward();
      test_forward_priority();
      test_xzr();
      test_redir_ignores_decode();
      test_reset_mid_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
